alu_rr_arbiter: RTL

- Shares one instance of the team's 8-bit combinational ALU between NREQ requesters.
- Round-robin arbitration, one operation accepted per cycle, 2-stage registered pipeline (operand stage, result stage).
- Result is returned with the winner's ID and a valid/ready handshake that supports backpressure.
- Sits between client engines and the single ALU; requesters see a request/grant interface, the consumer sees a result stream.

---
 rtl/alu_rr_arbiter_if.sv | 27 ++
 rtl/alu_rr_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter_if.sv
// Request/grant and result-stream bundle between client engines, the shared-ALU
// arbiter and the result consumer.
interface alu_rr_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_i;
    logic [8*NREQ-1:0] a_i;
    logic [8*NREQ-1:0] b_i;
    logic [3*NREQ-1:0] op_i;
    logic [NREQ-1:0]   gnt_o;
    logic [7:0]        res_o;
    logic [IDW-1:0]    id_o;
    logic              valid_o;
    logic              ready_i;

    modport master (
        output req_i, a_i, b_i, op_i, ready_i,
        input  gnt_o, res_o, id_o, valid_o
    );

    modport slave (
        input  req_i, a_i, b_i, op_i, ready_i,
        output gnt_o, res_o, id_o, valid_o
    );
endinterface

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit combinational ALU between NREQ requesters,
// with an operand stage and a result stage that honours consumer backpressure.
module alu8 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            3'b000: y = a + b;
            3'b001: y = a - b;
            3'b010: y = a << b[2:0];
            3'b011: y = a >> b[2:0];
            3'b100: y = a & b;
            3'b101: y = a | b;
            3'b110: y = a ^ b;
            3'b111: y = {{(DATA_W-1){1'b0}}, (a == b)};
            default: y = '0;
        endcase
    end
endmodule

module alu_rr_arbiter #(
    parameter int NREQ = 4
) (
    input logic              clk,
    input logic              reset,
    alu_rr_arbiter_if.slave  bus
);
    localparam int IDW    = $clog2(NREQ);
    localparam int DATA_W = 8;

    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    win;
    logic [IDW-1:0]    ptr_nxt;
    logic              found;
    int                idx;
    logic              out_free;
    logic              s1_adv;
    logic              accept;

    logic              vld_p1;
    logic [DATA_W-1:0] a_p1;
    logic [DATA_W-1:0] b_p1;
    logic [2:0]        op_p1;
    logic [IDW-1:0]    id_p1;
    logic [DATA_W-1:0] alu_y;

    // Winner is the first requester at or after ptr, wrapping around
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && bus.req_i[idx]) begin
                win   = idx[IDW-1:0];
                found = 1'b1;
            end
        end
    end

    assign ptr_nxt  = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    assign out_free = !bus.valid_o || bus.ready_i;
    assign s1_adv   = vld_p1 && out_free;
    assign accept   = !reset && found && (!vld_p1 || s1_adv);
    assign bus.gnt_o = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            ptr         <= '0;
            bus.valid_o <= 1'b0;
            bus.res_o   <= '0;
            bus.id_o    <= '0;
        end else begin
            if (accept) begin
                vld_p1 <= 1'b1;
                ptr    <= ptr_nxt;
            end else if (s1_adv) begin
                vld_p1 <= 1'b0;
            end

            if (s1_adv) begin
                bus.valid_o <= 1'b1;
                bus.res_o   <= alu_y;
                bus.id_o    <= id_p1;
            end else if (bus.ready_i) begin
                bus.valid_o <= 1'b0;
            end
        end
    end

    // Stage 1: operand capture of the granted requester
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p1  <= bus.a_i[8*win +: 8];
            b_p1  <= bus.b_i[8*win +: 8];
            op_p1 <= bus.op_i[3*win +: 3];
            id_p1 <= win;
        end
    end

    // Stage 2 input: shared ALU fed straight from stage 1
    alu8 #(.DATA_W(DATA_W)) u_alu (
        .a  (a_p1),
        .b  (b_p1),
        .op (op_p1),
        .y  (alu_y)
    );
endmodule
